pipelined_reduce: RTL and testbench
===================================

PIPELINED_REDUCE -- requirements
Module: pipelined_reduce

Interface
REQ-001 The block SHALL have parameter LENGTH, default 8, the input vector width in bits, legal range 1 or more.
REQ-002 The block SHALL have parameter CHUNK, default 2, the number of input bits folded per pipeline stage, legal range 1 to LENGTH.
REQ-003 The block SHALL have parameter OP, default 0, the reduction operator: 0 = AND, 1 = OR, 2 = XOR; any other value SHALL behave as AND.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_data holds a vector to reduce.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  LENGTH  vector to reduce.
REQ-010 out_valid  output  1  out holds a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out  output  1  reduction of the accepted vector.
REQ-013 out_idx  output  clog2(LENGTH+1)  first-break index; present only with REDUCE_TRACE_EN.

Function
REQ-014 STAGES SHALL equal ceil(LENGTH/CHUNK); stage k SHALL fold bits [k*CHUNK, min((k+1)*CHUNK, LENGTH)-1] into the running partial result.
REQ-015 The partial result entering stage 0 SHALL be the identity of OP: 1 for AND, 0 for OR and XOR.
REQ-016 Each stage SHALL register its partial result, its valid bit, and the not-yet-folded input bits.
REQ-017 A transfer SHALL occur on a rising clk edge when in_valid and in_ready are both high; out SHALL be consumed when out_valid and out_ready are both high.
REQ-018 advance SHALL equal (not out_valid) or out_ready; in_ready SHALL equal advance; all stages SHALL shift only when advance is high.
REQ-019 The pipeline SHALL NOT collapse bubbles; when advance is low, every stage SHALL hold its contents.
REQ-020 Latency SHALL be exactly STAGES cycles from the accept edge to out_valid, provided advance stays high.
REQ-021 Sustained throughput SHALL be one vector per cycle while out_ready is held high.
REQ-022 out and out_valid SHALL be driven directly from the last stage register, with no combinational path from in_data.
REQ-023 When LENGTH is not a multiple of CHUNK, the last stage SHALL fold only the remaining bits.
REQ-024 If an accept and a consume occur in the same cycle, the block SHALL perform both, with no loss or duplication of results.
REQ-025 Results SHALL leave the block in acceptance order.

Reset
REQ-026 While rst is high at a clk edge, all stage valid bits, out_valid and out SHALL clear to 0, and out_idx SHALL clear to LENGTH.
REQ-027 in_ready SHALL be high in the cycle after reset.
REQ-028 Vectors in flight when rst is asserted SHALL be discarded and never appear at the output.
REQ-029 Reset SHALL take priority over any simultaneous transfer.

Configuration
REQ-030 With macro REDUCE_TRACE_EN defined, the block SHALL provide out_idx, carried through the pipeline alongside the partial result.
REQ-031 out_idx SHALL be the lowest bit index whose value differs from the OP identity (AND: first 0; OR/XOR: first 1), or LENGTH if no such bit exists.
REQ-032 With REDUCE_TRACE_EN undefined, out_idx and its registers SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (LENGTH=8, CHUNK=2, so STAGES=4, unless stated)
REQ-033 OP=0: present 8'hFF with out_ready=1 -> out_valid=1 and out=1 exactly 4 cycles later; with TRACE, out_idx=8.
REQ-034 OP=0: present 8'hF7 -> out=0; with TRACE, out_idx=3.
REQ-035 OP=2: stream 8'h01, 8'h03, 8'h07 on back-to-back cycles -> outputs 1, 0, 1 on three consecutive cycles starting 4 cycles after the first accept.
REQ-036 Hold out_ready=0 with 4 vectors in flight -> in_ready=0, out held stable; raise out_ready -> all 4 results drain in order, one per cycle.
REQ-037 Assert rst for one cycle with 3 vectors in flight -> no out_valid for those vectors; in_ready=1 on the next cycle.
REQ-038 LENGTH=5, CHUNK=2, OP=1: present 5'b10000 -> out=1 after 3 cycles; with TRACE, out_idx=4.

Source files
------------

// File: rtl/pipelined_reduce.sv
// pipelined_reduce: AND / OR / XOR reduction of an LENGTH-bit vector, folding CHUNK bits per stage.
// Define REDUCE_TRACE_EN to add out_idx, the lowest bit index that breaks the operator identity.
module pipelined_reduce #(
   parameter int LENGTH = 8,
   parameter int CHUNK  = 2,
   parameter int OP     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LENGTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef REDUCE_TRACE_EN
   output logic [$clog2(LENGTH+1)-1:0] out_idx,
`endif
   output logic              out
);

   localparam int STAGES = (LENGTH + CHUNK - 1) / CHUNK;
   // Any OP other than OR/XOR reduces as AND, whose identity is 1.
   localparam logic IDENT = (OP == 1 || OP == 2) ? 1'b0 : 1'b1;
`ifdef REDUCE_TRACE_EN
   localparam int IDX_W = $clog2(LENGTH + 1);
   localparam logic [IDX_W-1:0] NO_BREAK = IDX_W'(LENGTH);
`endif

   logic advance;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO     = gi * CHUNK;
      localparam int HI     = ((gi + 1) * CHUNK < LENGTH) ? (gi + 1) * CHUNK : LENGTH;
      localparam int IN_W   = LENGTH - LO;
      localparam int REST_W = LENGTH - HI;

      logic            valid_in;
      logic            partial_in;
      logic [IN_W-1:0] data_in;
      logic            partial_next;
      logic            valid_reg;
      logic            partial_reg;
`ifdef REDUCE_TRACE_EN
      logic [IDX_W-1:0] idx_in;
      logic [IDX_W-1:0] idx_next;
      logic [IDX_W-1:0] idx_reg;
`endif

      if (gi == 0) begin : g_head
         assign valid_in   = in_valid;
         assign partial_in = IDENT;
         assign data_in    = in_data;
`ifdef REDUCE_TRACE_EN
         assign idx_in     = NO_BREAK;
`endif
      end else begin : g_link
         assign valid_in   = g_stage[gi-1].valid_reg;
         assign partial_in = g_stage[gi-1].partial_reg;
         assign data_in    = g_stage[gi-1].g_rest.rest_reg;
`ifdef REDUCE_TRACE_EN
         assign idx_in     = g_stage[gi-1].idx_reg;
`endif
      end

      // Bit 0 of data_in is always global bit LO; the stage folds [LO, HI).
      always_comb begin
         partial_next = partial_in;
         for (int b = 0; b < HI - LO; b++) begin
            case (OP)
               1:       partial_next = partial_next | data_in[b];
               2:       partial_next = partial_next ^ data_in[b];
               default: partial_next = partial_next & data_in[b];
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_reg   <= 1'b0;
            partial_reg <= 1'b0;
         end else if (advance) begin
            valid_reg   <= valid_in;
            partial_reg <= partial_next;
         end
      end

`ifdef REDUCE_TRACE_EN
      always_comb begin
         idx_next = idx_in;
         for (int b = 0; b < HI - LO; b++) begin
            if (idx_next == NO_BREAK && data_in[b] != IDENT)
               idx_next = IDX_W'(LO + b);
         end
      end

      always_ff @(posedge clk) begin
         if (rst)
            idx_reg <= NO_BREAK;
         else if (advance)
            idx_reg <= idx_next;
      end
`endif

      // Only bits still to be folded travel on; the last stage carries none.
      if (REST_W > 0) begin : g_rest
         logic [REST_W-1:0] rest_reg;
         always_ff @(posedge clk) begin
            if (advance)
               rest_reg <= data_in[IN_W-1:HI-LO];
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].valid_reg;
   assign out       = g_stage[STAGES-1].partial_reg;
`ifdef REDUCE_TRACE_EN
   assign out_idx   = g_stage[STAGES-1].idx_reg;
`endif
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

endmodule

// File: tb/tb_pipelined_reduce.sv
// Scoreboard bench for pipelined_reduce: three instances (8-bit AND, 8-bit XOR, 5-bit OR) share stimulus.
// Optional REDUCE_TRACE_EN also checks out_idx.
module tb_pipelined_reduce;

   localparam int ND = 3;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [7:0]    in_data;
   logic [ND-1:0] ov;
   logic [ND-1:0] o;
   logic [ND-1:0] ir;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[ND][$];

`ifdef REDUCE_TRACE_EN
   logic [3:0] idx_and;
   logic [3:0] idx_xor;
   logic [2:0] idx_or5;
   int         oidx[ND];
   assign oidx[0] = int'(idx_and);
   assign oidx[1] = int'(idx_xor);
   assign oidx[2] = int'(idx_or5);
`endif

   pipelined_reduce #(.LENGTH(8), .CHUNK(2), .OP(0)) u_and (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
      .out_valid(ov[0]), .out_ready(out_ready),
`ifdef REDUCE_TRACE_EN
      .out_idx(idx_and),
`endif
      .out(o[0]));

   pipelined_reduce #(.LENGTH(8), .CHUNK(2), .OP(2)) u_xor (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
      .out_valid(ov[1]), .out_ready(out_ready),
`ifdef REDUCE_TRACE_EN
      .out_idx(idx_xor),
`endif
      .out(o[1]));

   pipelined_reduce #(.LENGTH(5), .CHUNK(2), .OP(1)) u_or5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data[4:0]),
      .out_valid(ov[2]), .out_ready(out_ready),
`ifdef REDUCE_TRACE_EN
      .out_idx(idx_or5),
`endif
      .out(o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int len_of(int d);
      return (d == 2) ? 5 : 8;
   endfunction

   function automatic int op_of(int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
   endfunction

   function automatic int stages_of(int d);
      return (d == 2) ? 3 : 4;
   endfunction

   // Reference: count ones, decide by operator; index = first bit unlike the identity.
   function automatic int ref_model(logic [7:0] v, int len, int op);
      int   ones = 0;
      int   idx  = len;
      int   r;
      logic ident = (op == 1 || op == 2) ? 1'b0 : 1'b1;
      for (int i = 0; i < len; i++) begin
         if (v[i]) ones++;
         if (idx == len && v[i] != ident) idx = i;
      end
      case (op)
         1:       r = (ones > 0) ? 1 : 0;
         2:       r = ones % 2;
         default: r = (ones == len) ? 1 : 0;
      endcase
      return idx * 2 + r;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue side: push the expected result of every accepted vector.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (rst) exp_q[d].delete();
         else if (in_valid && ir[d])
            exp_q[d].push_back(ref_model(in_data, len_of(d), op_of(d)));
      end
   end

   // Monitor: compare whatever the DUT presents against the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < ND; d++) begin
            check($sformatf("in_ready%0d", d), int'(ir[d]), int'(!ov[d] || out_ready));
            if (ov[d]) begin
               if (exp_q[d].size() == 0) begin
                  check($sformatf("unexpected_out%0d", d), 1, 0);
               end else begin
                  check($sformatf("out%0d", d), int'(o[d]), exp_q[d][0] % 2);
`ifdef REDUCE_TRACE_EN
                  check($sformatf("out_idx%0d", d), oidx[d], exp_q[d][0] / 2);
`endif
                  if (out_ready) void'(exp_q[d].pop_front());
               end
            end
         end
      end
   end

   task automatic measure_latency(logic [7:0] v);
      int lat[ND];
      for (int d = 0; d < ND; d++) lat[d] = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = v;
      tick();
      in_valid  = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++)
            if (lat[d] == 0 && ov[d]) lat[d] = n;
      end
      for (int d = 0; d < ND; d++)
         check($sformatf("latency%0d_%02h", d, v), lat[d], stages_of(d));
      tick();
   endtask

   task automatic xor_stream();
      logic [7:0] vecs[3];
      vecs[0] = 8'h01; vecs[1] = 8'h03; vecs[2] = 8'h07;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = vecs[i];
         tick();
      end
      in_valid = 1'b0;
      for (int n = 3; n <= 7; n++) begin
         @(negedge clk);
         check($sformatf("xor_stream_valid_n%0d", n), int'(ov[1]), (n >= 4 && n <= 6) ? 1 : 0);
         if (n >= 4 && n <= 6)
            check($sformatf("xor_stream_out_n%0d", n), int'(o[1]), (n == 5) ? 0 : 1);
      end
      tick();
   endtask

   task automatic stall_drain();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stall_in_ready_and", int'(ir[0]), 0);
      check("stall_in_ready_xor", int'(ir[1]), 0);
      check("stall_out_valid_and", int'(ov[0]), 1);
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check($sformatf("drain_valid_and_%0d", n), int'(ov[0]), (n < 4) ? 1 : 0);
      end
      tick();
   endtask

   task automatic reset_in_flight();
      int seen = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      @(negedge clk);
      for (int d = 0; d < ND; d++)
         check($sformatf("after_rst_in_ready%0d", d), int'(ir[d]), 1);
      for (int n = 0; n < 8; n++) begin
         if (n > 0) @(negedge clk);
         if (ov != '0) seen++;
      end
      check("flushed_valid_cycles", seen, 0);
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      tick();
      tick();
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("rst_out_valid%0d", d), int'(ov[d]), 0);
         check($sformatf("rst_out%0d", d), int'(o[d]), 0);
`ifdef REDUCE_TRACE_EN
         check($sformatf("rst_out_idx%0d", d), oidx[d], len_of(d));
`endif
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < ND; d++)
         check($sformatf("post_rst_in_ready%0d", d), int'(ir[d]), 1);
      tick();

      measure_latency(8'hFF);
      measure_latency(8'hF7);
      measure_latency(8'h10);
      xor_stream();
      stall_drain();
      reset_in_flight();

      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      @(negedge clk);
      for (int d = 0; d < ND; d++)
         check($sformatf("queue_empty%0d", d), exp_q[d].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
